// File: rtl/ssr_fir_filter_if.sv
// Sample/coefficient/status bundle for ssr_fir_filter.
//   data_i / data_valid_i        : input block, NSAMPS lanes of NBITS (lane 0 earliest)
//   data_o / data_valid_o        : filtered block, NSAMPS lanes of OBITS, saturated
//   coeff_wr_i/addr_i/dat_i      : shadow coefficient bank write port
//   coeff_commit_i / coeff_busy_o: shadow-to-active swap request / swap pending
//   sat_o / sat_clr_i            : sticky saturation flag and its clear
// slave is the filter's view, master is the driver's view.
interface ssr_fir_filter_if #(
  parameter int NBITS  = 12,
  parameter int NSAMPS = 8,
  parameter int CBITS  = 4,
  parameter int OBITS  = 18,
  parameter int ABITS  = 6
);
  logic [NBITS*NSAMPS-1:0] data_i;
  logic                    data_valid_i;
  logic [OBITS*NSAMPS-1:0] data_o;
  logic                    data_valid_o;
  logic                    coeff_wr_i;
  logic [ABITS-1:0]        coeff_addr_i;
  logic [CBITS-1:0]        coeff_dat_i;
  logic                    coeff_commit_i;
  logic                    coeff_busy_o;
  logic                    sat_o;
  logic                    sat_clr_i;

  modport slave (
    input  data_i, data_valid_i, coeff_wr_i, coeff_addr_i, coeff_dat_i,
           coeff_commit_i, sat_clr_i,
    output data_o, data_valid_o, coeff_busy_o, sat_o
  );

  modport master (
    output data_i, data_valid_i, coeff_wr_i, coeff_addr_i, coeff_dat_i,
           coeff_commit_i, sat_clr_i,
    input  data_o, data_valid_o, coeff_busy_o, sat_o
  );
endinterface

// File: rtl/ssr_fir_filter.sv
// Super-sample-rate FIR: NSAMPS samples per clock convolved with NTAPS signed
// run-time coefficients from a double-buffered bank, NSAMPS saturated outputs
// per block. Latency 3 + clog2(NTAPS) clocks, one block per clock.
//   aclk, aclk_rst : clock, asynchronous active-high reset
//   bus (slave)    : data, coefficient and status signals (ssr_fir_filter_if)
module ssr_fir_filter #(
  parameter int NBITS  = 12,
  parameter int NSAMPS = 8,
  parameter int NTAPS  = 42,
  parameter int CBITS  = 4,
  parameter int OBITS  = 18,
  parameter int ABITS  = $clog2(NTAPS)
) (
  input  logic           aclk,
  input  logic           aclk_rst,
  ssr_fir_filter_if.slave bus
);
  localparam int ACCW = NBITS + CBITS + ABITS;
  localparam int LV   = $clog2(NTAPS);
  localparam int TP   = 1 << LV;
  localparam int HB   = (NTAPS + NSAMPS - 2) / NSAMPS + 1;
  localparam int HS   = HB * NSAMPS;
  localparam int BASE = (HB - 1) * NSAMPS;

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PENDING = 1'b1;

  typedef logic signed [ACCW-1:0]  acc_t;
  typedef logic signed [NBITS-1:0] smp_t;
  typedef logic signed [CBITS-1:0] cof_t;

  localparam acc_t SAT_MAX = acc_t'((2 ** (OBITS - 1)) - 1);
  localparam acc_t SAT_MIN = acc_t'(-(2 ** (OBITS - 1)));

  logic [0:0]              state_q;
  cof_t                    shadow_q [NTAPS];
  cof_t                    active_q [NTAPS];
  // Flattened sample history, oldest first; the newest block occupies [BASE +: NSAMPS].
  smp_t                    hist_q   [HS];
  // Level 0 holds the products, level LV node 0 the full sum per lane.
  acc_t                    tree_q   [LV+1][NSAMPS][TP];
  logic [LV+1:0]           vld_q;
  logic [OBITS*NSAMPS-1:0] dout_q;
  logic                    dvld_q;
  logic                    sat_q;
  logic [OBITS*NSAMPS-1:0] sat_val;
  logic                    sat_any;

  // Swap happens on the same edge that captures the first block using the new
  // bank. Products read active_q one cycle after capture, and active_q can only
  // change on a later capture edge, so a block never sees mixed banks.
  always_ff @(posedge aclk or posedge aclk_rst) begin
    if (aclk_rst) begin
      state_q <= IDLE;
      for (int unsigned k = 0; k < NTAPS; k++) begin
        shadow_q[k] <= (k == 0) ? cof_t'(1) : '0;
        active_q[k] <= (k == 0) ? cof_t'(1) : '0;
      end
    end else begin
      case (state_q)
        IDLE:    if (bus.coeff_commit_i) state_q <= PENDING;
        default: if (bus.data_valid_i) begin
                   state_q  <= IDLE;
                   active_q <= shadow_q;
                 end
      endcase
      if (state_q == IDLE && bus.coeff_wr_i && int'(bus.coeff_addr_i) < NTAPS)
        shadow_q[bus.coeff_addr_i] <= bus.coeff_dat_i;
    end
  end

  always_ff @(posedge aclk or posedge aclk_rst) begin
    if (aclk_rst) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < HS; i++) hist_q[i] <= '0;
      for (int unsigned l = 0; l <= LV; l++)
        for (int unsigned m = 0; m < NSAMPS; m++)
          for (int unsigned i = 0; i < TP; i++) tree_q[l][m][i] <= '0;
    end else begin
      vld_q <= {vld_q[LV:0], bus.data_valid_i};
      if (bus.data_valid_i) begin
        for (int unsigned i = 0; i < BASE; i++) hist_q[i] <= hist_q[i + NSAMPS];
        for (int unsigned i = 0; i < NSAMPS; i++)
          hist_q[BASE + i] <= bus.data_i[NBITS*i +: NBITS];
      end
      for (int unsigned m = 0; m < NSAMPS; m++) begin
        for (int unsigned k = 0; k < NTAPS; k++)
          tree_q[0][m][k] <= acc_t'(hist_q[BASE + m - k]) * acc_t'(active_q[k]);
        for (int unsigned k = NTAPS; k < TP; k++) tree_q[0][m][k] <= '0;
      end
      for (int unsigned l = 1; l <= LV; l++)
        for (int unsigned m = 0; m < NSAMPS; m++) begin
          for (int unsigned i = 0; i < (TP >> l); i++)
            tree_q[l][m][i] <= tree_q[l-1][m][2*i] + tree_q[l-1][m][2*i+1];
          for (int unsigned i = (TP >> l); i < TP; i++) tree_q[l][m][i] <= '0;
        end
    end
  end

  always_comb begin
    sat_val = '0;
    sat_any = 1'b0;
    for (int unsigned m = 0; m < NSAMPS; m++) begin
      if (tree_q[LV][m][0] > SAT_MAX) begin
        sat_val[OBITS*m +: OBITS] = SAT_MAX[OBITS-1:0];
        sat_any = 1'b1;
      end else if (tree_q[LV][m][0] < SAT_MIN) begin
        sat_val[OBITS*m +: OBITS] = SAT_MIN[OBITS-1:0];
        sat_any = 1'b1;
      end else begin
        sat_val[OBITS*m +: OBITS] = tree_q[LV][m][0][OBITS-1:0];
      end
    end
  end

  // Set has priority over clear when both land on the same edge.
  always_ff @(posedge aclk or posedge aclk_rst) begin
    if (aclk_rst) begin
      dout_q <= '0;
      dvld_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      dout_q <= sat_val;
      dvld_q <= vld_q[LV+1];
      sat_q  <= (sat_q & ~bus.sat_clr_i) | (vld_q[LV+1] & sat_any);
    end
  end

  assign bus.data_o       = dout_q;
  assign bus.data_valid_o = dvld_q;
  assign bus.sat_o        = sat_q;
  assign bus.coeff_busy_o = (state_q == PENDING);
endmodule

// File: tb/tb_ssr_fir_filter.sv
// Scoreboard bench for ssr_fir_filter: the driver computes each block's
// expected output with a direct convolution and queues it; the monitor pops
// and compares whenever data_valid_o is high, also checking latency and sat_o.
module tb_ssr_fir_filter;
  localparam int NB = 12, NS = 8, NT = 42, CB = 4, OB = 18, AB = 6, LAT = 9;
  localparam int DW = OB * NS;
  localparam int SMAX = 131071, SMIN = -131072;

  logic aclk = 1'b0;
  logic aclk_rst = 1'b1;

  ssr_fir_filter_if #(.NBITS(NB), .NSAMPS(NS), .CBITS(CB), .OBITS(OB), .ABITS(AB)) bus ();

  ssr_fir_filter #(.NBITS(NB), .NSAMPS(NS), .NTAPS(NT), .CBITS(CB), .OBITS(OB), .ABITS(AB)) dut (
    .aclk(aclk), .aclk_rst(aclk_rst), .bus(bus)
  );

  always #5 aclk = ~aclk;

  typedef struct { logic [DW-1:0] data; int cyc; bit clamp; } exp_t;
  exp_t sb[$];
  int   n_chk = 0, n_fail = 0, cyc = 0;
  int   xs[$];
  int   h_act [NT];
  int   h_sh  [NT];
  bit   pend_m = 1'b0;
  bit   sat_m  = 1'b0;

  function automatic void check(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic void model_reset();
    xs.delete();
    for (int k = 0; k < NT; k++) begin
      h_act[k] = (k == 0) ? 1 : 0;
      h_sh[k]  = (k == 0) ? 1 : 0;
    end
    pend_m = 1'b0;
  endfunction

  function automatic logic [NB*NS-1:0] blk(int base, int step);
    logic [NB*NS-1:0] r;
    for (int i = 0; i < NS; i++) r[NB*i +: NB] = NB'(base + step * i);
    return r;
  endfunction

  task automatic drive(input bit v, input logic [NB*NS-1:0] d, input bit wr = 0,
                       input int addr = 0, input int dat = 0, input bit cm = 0,
                       input bit clr = 0);
    bit   was;
    exp_t e;
    logic signed [NB-1:0] s;
    @(negedge aclk);
    check("coeff_busy", DW'(bus.coeff_busy_o), DW'(pend_m));
    bus.data_valid_i   = v;
    bus.data_i         = d;
    bus.coeff_wr_i     = wr;
    bus.coeff_addr_i   = AB'(addr);
    bus.coeff_dat_i    = CB'(dat);
    bus.coeff_commit_i = cm;
    bus.sat_clr_i      = clr;
    was = pend_m;
    if (v && was) begin
      h_act  = h_sh;
      pend_m = 1'b0;
    end
    if (wr && !was && addr >= 0 && addr < NT) h_sh[addr] = dat;
    if (cm && !was) pend_m = 1'b1;
    if (v) begin
      for (int i = 0; i < NS; i++) begin
        s = d[NB*i +: NB];
        xs.push_back(int'(s));
      end
      e.data  = '0;
      e.clamp = 1'b0;
      e.cyc   = cyc + LAT;
      for (int m = 0; m < NS; m++) begin
        int n, acc;
        n   = xs.size() - NS + m;
        acc = 0;
        for (int k = 0; k < NT; k++)
          if (n - k >= 0) acc += h_act[k] * xs[n - k];
        if (acc > SMAX) begin acc = SMAX; e.clamp = 1'b1; end
        if (acc < SMIN) begin acc = SMIN; e.clamp = 1'b1; end
        e.data[OB*m +: OB] = OB'(acc);
      end
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, '0);
  endtask

  always @(posedge aclk) begin
    exp_t e;
    bit   cl;
    cyc++;
    #1;
    cl = 1'b0;
    if (aclk_rst) begin
      sat_m = 1'b0;
    end else begin
      if (bus.data_valid_o) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_valid: got data_valid_o=1 at cycle %0d, required no output", cyc);
        end else begin
          e = sb.pop_front();
          check("data_o", bus.data_o, e.data);
          check("latency", DW'(cyc), DW'(e.cyc));
          cl = e.clamp;
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL missing_valid: got data_valid_o=0 at cycle %0d, required output due at %0d", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      sat_m = (sat_m & ~bus.sat_clr_i) | cl;
      check("sat_o", DW'(bus.sat_o), DW'(sat_m));
    end
  end

  initial begin
    logic [NB*NS-1:0] imp;
    bus.data_i = '0;  bus.data_valid_i = 1'b0;
    bus.coeff_wr_i = 1'b0;  bus.coeff_addr_i = '0;  bus.coeff_dat_i = '0;
    bus.coeff_commit_i = 1'b0;  bus.sat_clr_i = 1'b0;
    model_reset();
    #1;
    check("reset_data", bus.data_o, '0);
    check("reset_valid", DW'(bus.data_valid_o), '0);
    check("reset_busy", DW'(bus.coeff_busy_o), '0);
    check("reset_sat", DW'(bus.sat_o), '0);
    #11 aclk_rst = 1'b0;

    // Default impulse bank: pure delay with sign extension.
    for (int b = 0; b < 4; b++) drive(1, blk(-350, 100));
    idle(10);

    // Impulse response with h[k] = (k%15)-7.
    for (int k = 0; k < NT; k++) drive(0, '0, 1, k, (k % 15) - 7);
    drive(0, '0, 1, 63, 3);
    for (int b = 0; b < 6; b++) drive(1, '0);
    drive(0, '0, 0, 0, 0, 1);
    imp = '0;
    imp[NB-1:0] = NB'(100);
    drive(1, imp);
    for (int b = 0; b < 6; b++) drive(1, '0);
    idle(10);

    // Commit boundary with bubbles and a write attempted while busy.
    drive(0, '0, 1, 0, 2);
    drive(1, blk(10, 1));
    drive(0, '0, 0, 0, 0, 1);
    drive(0, '0);
    drive(0, '0, 1, 1, 7);
    drive(0, '0, 0, 0, 0, 1);
    drive(0, '0);
    drive(0, '0);
    drive(1, blk(20, -3));
    drive(1, blk(-5, 2));
    idle(10);

    // Saturation, set-wins-over-clear, negative clamp, then clear.
    for (int k = 0; k < NT; k++) drive(0, '0, 1, k, -8);
    drive(0, '0, 0, 0, 0, 1);
    for (int b = 0; b < 12; b++) drive(1, blk(-2048, 0), 0, 0, 0, 0, b == 10);
    for (int b = 0; b < 7; b++) drive(1, blk(2047, 0));
    for (int b = 0; b < 8; b++) drive(1, '0);
    idle(12);
    drive(0, '0, 0, 0, 0, 0, 1);
    idle(3);

    // Bubbles: alternate valid/invalid with garbage on the invalid cycles.
    for (int b = 0; b < 10; b++) begin
      drive(1, blk(8 * b, 1));
      drive(0, {NS{12'hA5A}});
    end
    idle(10);

    // Mid-stream asynchronous reset with blocks in flight and a commit pending.
    drive(0, '0, 1, 0, 5);
    for (int b = 0; b < 5; b++) drive(1, blk(3 * b, 5));
    drive(0, '0, 0, 0, 0, 1);
    @(posedge aclk);
    #3 aclk_rst = 1'b1;
    #1;
    check("midrst_data", bus.data_o, '0);
    check("midrst_valid", DW'(bus.data_valid_o), '0);
    check("midrst_busy", DW'(bus.coeff_busy_o), '0);
    check("midrst_sat", DW'(bus.sat_o), '0);
    sb.delete();
    model_reset();
    @(posedge aclk);
    #3 aclk_rst = 1'b0;
    for (int b = 0; b < 4; b++) drive(1, blk(5 - 40 * b, -3));
    idle(12);

    for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1);
    check("scoreboard_empty", DW'(sb.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ssr_fir_filter.md
# ssr_fir_filter

Parametrised SSR FIR filter: the run-time-programmable successor of the fixed 42-tap PUEO matched filter. Each clock it accepts NSAMPS parallel samples, where lane 0 is the earliest sample in the block and lane NSAMPS-1 the latest. It convolves them with NTAPS signed coefficients held in a double-buffered bank and emits NSAMPS saturated outputs per block. It sits between the sample capture path and the trigger/beamforming logic, one instance per channel. Coefficients are reloaded over a simple write port and committed glitch-free on a block boundary.

## Interface
- NBITS, 12, input sample width (signed)
- NSAMPS, 8, samples per clock (SSR factor)
- NTAPS, 42, filter length
- CBITS, 4, coefficient width (signed)
- OBITS, 18, output width (signed, saturated)
- ABITS, $clog2(NTAPS), coefficient address width (derived)

Ports:
- aclk  in  1  clock
- aclk_rst  in  1  reset; **one clock; reset is asynchronous and active-high**
- data_i  in  NBITS*NSAMPS  input block; lane i is at [NBITS*i +: NBITS]
- data_valid_i  in  1  block valid
- data_o  out  OBITS*NSAMPS  output block, same lane order
- data_valid_o  out  1  output valid
- coeff_wr_i  in  1  shadow-bank write strobe
- coeff_addr_i  in  ABITS  tap index k (0..NTAPS-1)
- coeff_dat_i  in  CBITS  coefficient h[k]
- coeff_commit_i  in  1  request a shadow-to-active swap
- coeff_busy_o  out  1  commit pending
- sat_o  out  1  sticky saturation flag
- sat_clr_i  in  1  clear sat_o

## Operation
- Function: y[n] = sum over k=0..NTAPS-1 of h[k]*x[n-k], where n = NSAMPS*b + lane. History spans ceil((NTAPS-1)/NSAMPS)+1 blocks.
- History advances only on data_valid_i=1. Invalid cycles are bubbles: the history is held, and the bubble propagates through the valid shift register with no output.
- Full-precision sum width is ACCW = NBITS+CBITS+ABITS; no intermediate truncation.
- Each output is clamped to [-2^(OBITS-1), 2^(OBITS-1)-1].
- If any lane clamps in a valid output cycle, sat_o is set. sat_clr_i clears it. If set and clear occur in the same cycle, set wins.
- Coefficient writes:
  - coeff_wr_i writes the shadow bank at coeff_addr_i.
  - Addresses >= NTAPS are ignored.
  - Writes while coeff_busy_o=1 are ignored.
- Commit state machine: IDLE, PENDING.
  - IDLE to PENDING on coeff_commit_i; coeff_busy_o goes to 1 on the next cycle.
  - PENDING to IDLE on the first edge with data_valid_i=1. At that edge active <= shadow, and the block accepted at that same edge is the first block computed with the new bank.
  - coeff_commit_i while in PENDING is ignored.
  - Every output block is computed entirely with one bank; no per-tap mixing is allowed.
- Reset (asynchronous, any time, including mid-stream):
  - History, pipeline registers, data_o, data_valid_o, sat_o and coeff_busy_o go to 0; state goes to IDLE.
  - Both banks reset to the impulse h[0]=1, h[k>0]=0. The block then acts as a pure delay with sign extension.

## Timing
- Pipeline stages:
  1. Input capture and bank swap.
  2. Registered products.
  3. ceil(log2 NTAPS) registered 2-input adder-tree levels.
  4. Saturate register.
- Latency L = 3 + ceil(log2 NTAPS) clocks from data_valid_i to data_valid_o; L = 9 for the defaults. The latency is fixed and independent of bubbles.
- Throughput is one block per clock with no backpressure.
- Shadow writes take effect one cycle later and never affect in-flight blocks.

## Test plan
- Reset defaults: after reset, send blocks where lane i = 100*i-350 for 4 blocks. Required: the identical values sign-extended to OBITS appear with data_valid_o exactly 9 clocks later, and sat_o=0.
- Impulse response: load h[k]=(k%15)-7 and commit. Feed one block with lane0=100 and all other samples 0, followed by zero blocks. Required: output block b+j, lane m equals 100*h[8j+m] for 8j+m<42, and 0 elsewhere.
- Commit boundary: assert commit, then hold data_valid_i=0 for 5 cycles. Required: coeff_busy_o=1 throughout. The first valid block switches banks, the prior output block uses the old bank, the next uses the new bank, and coeff_busy_o falls one cycle after the swap. Writes issued while busy leave the shadow unchanged.
- Saturation: set all h=-8 and feed all samples -2048. Required: outputs 131071 and sat_o=1. With sat_o set, assert sat_clr_i together with another saturating block: sat_o stays 1. Clear with non-saturating data: sat_o=0.
- Bubbles: alternate data_valid_i 1/0 with a ramp input. Required: the output equals the bubble-free result, with valid spacing preserved and latency of 9.
- Mid-stream reset: assert aclk_rst asynchronously, between edges, while 5 blocks are in flight and a commit is pending. Required: all outputs are 0 immediately, no stale valid appears afterwards, the state is IDLE, and the banks are restored to the impulse.
